serial_frame_receiver: RTL and testbench

//  Parametrised successor of the fixed 40-bit keyboard/sound serial receiver. Captures start-bit framed,
//  one-bit-per-clk serial frames of DATA_BITS bits. Selectable bit order and stop-bit checking.

---
 rtl/serial_frame_receiver_pkg.sv | 18 +
 rtl/rx_frame_fifo.sv | 60 ++++++
 rtl/serial_frame_receiver.sv | 103 ++++++++++
 tb/tb_serial_frame_receiver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_receiver_pkg.sv
// Shared types and defaults for the serial frame receiver and its frame FIFO.
package serial_frame_receiver_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StData = 2'd1,
    StStop = 2'd2
  } rx_state_e;

  localparam int unsigned DefaultDataBits  = 40;
  localparam int unsigned DefaultFifoDepth = 2;

  // Pointer width that stays at least one bit wide for a single-entry FIFO.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rx_frame_fifo.sv
// Synchronous frame FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module rx_frame_fifo
  import serial_frame_receiver_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultDataBits,
  parameter int unsigned DEPTH = DefaultFifoDepth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = clog2_min1(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CntW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Start-bit framed serial receiver, one bit per clk, with stop check and a buffered
// valid/ready output.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DefaultDataBits,
  parameter int unsigned FIFO_DEPTH = DefaultFifoDepth,
  parameter int unsigned LSB_FIRST  = 1,
  parameter int unsigned CHECK_STOP = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 si,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(DATA_BITS);

  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 push_req, pop, fifo_full, fifo_empty;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (si) begin
          state_d = StData;
          cnt_d   = '0;
        end
      end
      StData: begin
        sr_d  = (LSB_FIRST != 0) ? {si, sr_q[DATA_BITS-1:1]} : {sr_q[DATA_BITS-2:0], si};
        cnt_d = cnt_q + 1'b1;
        // Return the counter to zero on the last bit so it never passes DATA_BITS-1.
        if (cnt_q == CntW'(DATA_BITS - 1)) begin
          state_d = StStop;
          cnt_d   = '0;
        end
      end
      StStop: begin
        state_d = StIdle;
        if ((CHECK_STOP != 0) && si) begin
          frame_err_d = 1'b1;
        end else begin
          push_req = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop       = out_ready && !fifo_empty;
  assign overrun_d = push_req && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sr_q        <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  rx_frame_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_req),
    .push_data(sr_q),
    .pop      (pop),
    .head_data(out_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: three configurations checked every cycle against a frame-level
// queue model.
module tb_serial_frame_receiver;

  localparam int unsigned DEPTH = 2;

  logic        clk, rst_n;
  logic        si, ready_ab, si_c, ready_c;
  logic [7:0]  out_data_a, out_data_b;
  logic [39:0] out_data_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic        frame_err_a, frame_err_b, frame_err_c;
  logic        overrun_a, overrun_b, overrun_c;
  logic        busy_a, busy_b, busy_c;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: expected FIFO contents and the events the stimulus schedules at the next edge.
  logic [7:0]  qa[$], qb[$];
  logic [39:0] qc[$];
  logic        ev_stop_ab = 1'b0, ev_stopbit = 1'b0, ev_busy_ab = 1'b0;
  logic        ev_stop_c = 1'b0, ev_busy_c = 1'b0;
  logic [7:0]  ev_frame_a, ev_frame_b;
  logic [39:0] ev_frame_c;

  serial_frame_receiver #(
    .DATA_BITS(8), .FIFO_DEPTH(DEPTH), .LSB_FIRST(1), .CHECK_STOP(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .si(si), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(ready_ab), .frame_err(frame_err_a), .overrun(overrun_a), .busy(busy_a)
  );

  serial_frame_receiver #(
    .DATA_BITS(8), .FIFO_DEPTH(DEPTH), .LSB_FIRST(0), .CHECK_STOP(0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .si(si), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(ready_ab), .frame_err(frame_err_b), .overrun(overrun_b), .busy(busy_b)
  );

  serial_frame_receiver u_dut_c (
    .clk(clk), .rst_n(rst_n), .si(si_c), .out_data(out_data_c), .out_valid(out_valid_c),
    .out_ready(ready_c), .frame_err(frame_err_c), .overrun(overrun_c), .busy(busy_c)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: update the model at the edge, then compare every output at the falling edge.
  task automatic tick();
    logic err_a, ovr_a, ovr_b, err_c, ovr_c;
    @(posedge clk);
    err_a = 1'b0; ovr_a = 1'b0; ovr_b = 1'b0; err_c = 1'b0; ovr_c = 1'b0;
    if (ready_ab && qa.size() != 0) void'(qa.pop_front());
    if (ready_ab && qb.size() != 0) void'(qb.pop_front());
    if (ready_c && qc.size() != 0) void'(qc.pop_front());
    if (ev_stop_ab) begin
      if (ev_stopbit) err_a = 1'b1;
      else if (qa.size() == DEPTH) ovr_a = 1'b1;
      else qa.push_back(ev_frame_a);
      if (qb.size() == DEPTH) ovr_b = 1'b1;
      else qb.push_back(ev_frame_b);
    end
    if (ev_stop_c) begin
      if (qc.size() == DEPTH) ovr_c = 1'b1;
      else qc.push_back(ev_frame_c);
    end
    ev_stop_ab = 1'b0;
    ev_stop_c  = 1'b0;
    @(negedge clk);
    check("valid_a", out_valid_a, qa.size() != 0);
    if (qa.size() != 0) check("data_a", out_data_a, qa[0]);
    check("valid_b", out_valid_b, qb.size() != 0);
    if (qb.size() != 0) check("data_b", out_data_b, qb[0]);
    check("valid_c", out_valid_c, qc.size() != 0);
    if (qc.size() != 0) check("data_c", out_data_c, qc[0]);
    check("ferr_a", frame_err_a, err_a);
    check("ferr_b", frame_err_b, 1'b0);
    check("ferr_c", frame_err_c, err_c);
    check("ovr_a", overrun_a, ovr_a);
    check("ovr_b", overrun_b, ovr_b);
    check("ovr_c", overrun_c, ovr_c);
    check("busy_a", busy_a, ev_busy_ab);
    check("busy_b", busy_b, ev_busy_ab);
    check("busy_c", busy_c, ev_busy_c);
  endtask

  task automatic idle(input int n, input bit rand_rdy);
    si = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (rand_rdy) ready_ab = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  // r holds the bits in send order (r[0] first); the models derive each instance's word from it.
  task automatic send_ab(input logic [7:0] r, input bit stopbit, input bit rand_rdy,
                         input bit stop_rdy);
    logic [7:0] rev;
    for (int k = 0; k < 8; k++) rev[7-k] = r[k];
    ev_frame_a = r;
    ev_frame_b = rev;
    si = 1'b1;
    ev_busy_ab = 1'b1;
    if (rand_rdy) ready_ab = 1'($urandom_range(0, 1));
    tick();
    for (int k = 0; k < 8; k++) begin
      si = r[k];
      if (rand_rdy) ready_ab = 1'($urandom_range(0, 1));
      tick();
    end
    si = stopbit;
    ev_busy_ab = 1'b0;
    ev_stop_ab = 1'b1;
    ev_stopbit = stopbit;
    if (stop_rdy) ready_ab = 1'b1;
    else if (rand_rdy) ready_ab = 1'($urandom_range(0, 1));
    tick();
    si = 1'b0;
    if (stop_rdy) ready_ab = 1'b0;
  endtask

  task automatic drain_ab();
    ready_ab = 1'b1;
    idle(3, 1'b0);
    ready_ab = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_busy_c", busy_c, 1'b0);
    check("rst_valid_a", out_valid_a, 1'b0);
    check("rst_valid_c", out_valid_c, 1'b0);
    check("rst_data_c", out_data_c, 40'h0);
    check("rst_pulses", {frame_err_a, overrun_a, frame_err_c, overrun_c}, 4'h0);
    qa.delete(); qb.delete(); qc.delete();
    ev_busy_ab = 1'b0; ev_busy_c = 1'b0;
    si = 1'b0; si_c = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // abort_at > 0: reset after that many data bits instead of finishing the frame.
  task automatic send_c(input logic [39:0] d, input int abort_at, input bit rand_rdy);
    ev_frame_c = d;
    si_c = 1'b1;
    ev_busy_c = 1'b1;
    tick();
    for (int k = 0; k < 40; k++) begin
      if (abort_at > 0 && k == abort_at) begin
        do_reset();
        return;
      end
      si_c = d[k];
      if (rand_rdy) ready_c = 1'($urandom_range(0, 1));
      tick();
    end
    si_c = 1'b0;
    ev_busy_c = 1'b0;
    ev_stop_c = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0]  r;
    logic [39:0] d;
    rst_n = 1'b0; si = 1'b0; si_c = 1'b0; ready_ab = 1'b0; ready_c = 1'b0;
    @(negedge clk);
    do_reset();
    check("rst_data_a", out_data_a, 8'h00);
    idle(2, 1'b0);

    // Bits 1,0,1,1,0,0,0,0 with a good stop bit.
    send_ab(8'h0D, 1'b0, 1'b0, 1'b0);
    check("t1_data_lsb", out_data_a, 8'h0D);
    check("t2_data_msb", out_data_b, 8'hB0);
    drain_ab();

    // Bad stop bit: rejected with CHECK_STOP, accepted without.
    send_ab(8'h5A, 1'b1, 1'b0, 1'b0);
    check("t3_ferr_pulse", frame_err_a, 1'b1);
    check("t3_no_valid_a", out_valid_a, 1'b0);
    check("t3_valid_b", out_valid_b, 1'b1);
    drain_ab();

    // Three back-to-back frames with the consumer stalled: third overruns.
    send_ab(8'h11, 1'b0, 1'b0, 1'b0);
    send_ab(8'h22, 1'b0, 1'b0, 1'b0);
    send_ab(8'h33, 1'b0, 1'b0, 1'b0);
    check("t4_overrun", overrun_a, 1'b1);
    check("t4_head", out_data_a, 8'h11);
    drain_ab();

    // Full FIFO popped in the stop cycle of the third frame: no overrun.
    send_ab(8'h11, 1'b0, 1'b0, 1'b0);
    send_ab(8'h22, 1'b0, 1'b0, 1'b0);
    send_ab(8'h33, 1'b0, 1'b0, 1'b1);
    check("t5_no_overrun", overrun_a, 1'b0);
    check("t5_head", out_data_a, 8'h22);
    drain_ab();

    for (int i = 0; i < 30; i++) begin
      r = 8'($urandom);
      send_ab(r, $urandom_range(0, 7) == 0, 1'b1, 1'b0);
      idle($urandom_range(0, 2), 1'b1);
    end
    drain_ab();

    // 40-bit frames, including a reset at bit 20.
    for (int i = 0; i < 3; i++) begin
      d = {8'($urandom), 32'($urandom)};
      send_c(d, 0, 1'b1);
    end
    ready_c = 1'b1;
    tick(); tick();
    ready_c = 1'b0;
    send_c({8'hA5, 32'($urandom)}, 20, 1'b0);
    d = {8'($urandom), 32'($urandom)};
    send_c(d, 0, 1'b0);
    check("t6_valid", out_valid_c, 1'b1);
    check("t6_data", out_data_c, d);
    ready_c = 1'b1;
    tick();
    check("t6_one_frame", out_valid_c, 1'b0);
    ready_c = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
